// File: rtl/ex_div_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Optional macro DIV_FAST_SPECIAL_EN: finish divide-by-zero and signed overflow in one cycle.
module ex_div_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_valid_i,
    input  logic [1:0]      div_op_i,
    input  logic [XLEN-1:0] rs1_rdata_i,
    input  logic [XLEN-1:0] rs2_rdata_i,
    input  logic            flush_i,
    output logic            div_stall_o,
    output logic            div_done_o,
    output logic [XLEN-1:0] div_res_o
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] One = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0] LastStep = CntW'(XLEN - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] res_q, res_d;

    // Operand decode at acceptance
    logic            is_signed_in;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            ovf_in, q_neg_in, r_neg_in;

    assign is_signed_in = ~div_op_i[0];
    assign a_neg_in     = is_signed_in & rs1_rdata_i[XLEN-1];
    assign b_neg_in     = is_signed_in & rs2_rdata_i[XLEN-1];
    assign a_mag_in     = a_neg_in ? (~rs1_rdata_i + One) : rs1_rdata_i;
    assign b_mag_in     = b_neg_in ? (~rs2_rdata_i + One) : rs2_rdata_i;
    assign ovf_in       = is_signed_in & (rs1_rdata_i == MinVal) & (&rs2_rdata_i);
    assign q_neg_in     = (div_op_i == 2'b00) & (rs1_rdata_i[XLEN-1] ^ rs2_rdata_i[XLEN-1]);
    assign r_neg_in     = (div_op_i == 2'b10) & rs1_rdata_i[XLEN-1];

    // One restoring step on the latched magnitudes
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic            fits;
    logic [XLEN-1:0] rem_step, quot_step;

    assign rem_shift = {rem_q, quot_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, divisor_q};
    assign fits      = ~diff[XLEN];
    assign rem_step  = fits ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quot_step = {quot_q[XLEN-2:0], fits};

    function automatic logic [XLEN-1:0] result_mux(
        input logic [1:0]      op,
        input logic            div_zero,
        input logic            ovf,
        input logic [XLEN-1:0] dividend,
        input logic [XLEN-1:0] quot,
        input logic [XLEN-1:0] rem,
        input logic            q_neg,
        input logic            r_neg
    );
        logic [XLEN-1:0] res;
        if (div_zero) begin
            res = op[1] ? dividend : {XLEN{1'b1}};
        end else if (ovf) begin
            res = op[1] ? '0 : MinVal;
        end else if (op[1]) begin
            res = r_neg ? (~rem + One) : rem;
        end else begin
            res = q_neg ? (~quot + One) : quot;
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        ovf_d      = ovf_q;
        res_d      = res_q;

        unique case (state_q)
            StIdle: begin
                if (div_valid_i && !flush_i) begin
                    state_d    = StCalc;
                    cnt_d      = '0;
                    op_d       = div_op_i;
                    dividend_d = rs1_rdata_i;
                    divisor_d  = b_mag_in;
                    quot_d     = a_mag_in;
                    rem_d      = '0;
                    q_neg_d    = q_neg_in;
                    r_neg_d    = r_neg_in;
                    ovf_d      = ovf_in;
`ifdef DIV_FAST_SPECIAL_EN
                    if ((rs2_rdata_i == '0) || ovf_in) begin
                        state_d = StDone;
                        res_d   = result_mux(div_op_i, rs2_rdata_i == '0, ovf_in, rs1_rdata_i,
                                             '0, '0, 1'b0, 1'b0);
                    end
`endif
                end
            end
            StCalc: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    quot_d = quot_step;
                    rem_d  = rem_step;
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == LastStep) begin
                        state_d = StDone;
                        res_d   = result_mux(op_q, divisor_q == '0, ovf_q, dividend_q,
                                             quot_step, rem_step, q_neg_q, r_neg_q);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            ovf_q      <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            ovf_q      <= ovf_d;
            res_q      <= res_d;
        end
    end

    assign div_stall_o = div_valid_i & (state_q != StDone);
    assign div_done_o  = (state_q == StDone);
    assign div_res_o   = res_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: arithmetic reference model plus per-cycle output compare.
// Honours DIV_FAST_SPECIAL_EN for the expected special-case latency.
module tb_ex_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        done;
    logic [31:0] res;

    ex_div_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_valid_i(div_valid),
        .div_op_i   (op),
        .rs1_rdata_i(rs1),
        .rs2_rdata_i(rs2),
        .flush_i    (flush),
        .div_stall_o(stall),
        .div_done_o (done),
        .div_res_o  (res)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state: one outstanding operation and the last committed result
    bit          active = 1'b0;
    int          done_cyc = 0;
    logic [31:0] pend_res = '0;
    logic [31:0] commit_res = '0;

    localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [1:0] mop, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return mop[1] ? a : 32'hFFFF_FFFF;
        if (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return mop[1] ? 32'h0 : 32'h8000_0000;
        case (mop)
            OpDiv:   return sa / sb;
            OpDivu:  return a / b;
            OpRem:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] mop, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
        if (b == 32'h0 || (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    // Per-cycle compare of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit exp_done;
                exp_done = active && (cyc == done_cyc);
                if (exp_done) begin
                    commit_res = pend_res;
                    active = 1'b0;
                end
                chk("done", {31'b0, done}, {31'b0, exp_done});
                chk("stall", {31'b0, stall}, {31'b0, div_valid && !exp_done});
                chk("res", res, commit_res);
            end
        end
    end

    // Starts at #1 after a posedge with the DUT idle; returns likewise
    task automatic run_op(input string name, input logic [1:0] mop, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want);
        bit seen;
        op = mop;
        rs1 = a;
        rs2 = b;
        div_valid = 1'b1;
        pend_res = model_res(mop, a, b);
        done_cyc = cyc + model_lat(mop, a, b);
        active = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (i == 1) begin
                rs1 = $urandom;
                rs2 = $urandom;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: div_done_o not seen within 40 cycles", name);
        end else begin
            chk(name, res, want);
        end
        @(posedge clk);
        #1;
        div_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_res", res, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        rst_n = 1'b1;

        run_op("div_100_m7", OpDiv, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
        run_op("rem_100_m7", OpRem, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu_max_3", OpDivu, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
        run_op("remu_10_3", OpRemu, 32'd10, 32'd3, 32'h0000_0001);
        run_op("rem_m7_0", OpRem, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9);
        run_op("div_m7_0", OpDiv, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF);
        run_op("divu_5_0", OpDivu, 32'd5, 32'h0, 32'hFFFF_FFFF);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("remu_min_max", OpRemu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_m100_7", OpRem, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);

        // Flush during CALC step 10: no done pulse, result register untouched
        op = OpDiv;
        rs1 = 32'd1000;
        rs2 = 32'd7;
        div_valid = 1'b1;
        pend_res = model_res(OpDiv, 32'd1000, 32'd7);
        done_cyc = cyc + 33;
        active = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        active = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        div_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_op("divu_7_2", OpDivu, 32'd7, 32'd2, 32'h0000_0003);

        // Asynchronous reset mid-CALC
        op = OpDivu;
        rs1 = 32'd12345;
        rs2 = 32'd17;
        div_valid = 1'b1;
        pend_res = model_res(OpDivu, 32'd12345, 32'd17);
        done_cyc = cyc + 33;
        active = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        div_valid = 1'b0;
        active = 1'b0;
        commit_res = '0;
        #1;
        chk("midrst_done", {31'b0, done}, 32'h0);
        chk("midrst_res", res, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("div_9_3", OpDiv, 32'd9, 32'd3, 32'h0000_0003);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
